// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the WIDTH-bit carry chain is cut into STAGES
// equal slices, one slice resolved per register stage, with valid/ready flow.
module adder_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int S     = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             ovf_q
);
    localparam int LO = IDX * S;
    localparam int HI = LO + S - 1;

    logic [S:0]       slice;
    logic [WIDTH-1:0] s_next;
    logic             ovf_next;

    assign slice = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{S{1'b0}}, c_in};

    always_comb begin
        s_next        = s_in;
        s_next[HI:LO] = slice[S-1:0];
    end

    // Carry into the slice MSB is recovered as a^b^sum; only meaningful in the last stage.
    assign ovf_next = a_in[HI] ^ b_in[HI] ^ slice[S-1] ^ slice[S];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load) begin
            a_q   <= a_in;
            b_q   <= b_in;
            s_q   <= s_next;
            c_q   <= slice[S];
            ovf_q <= ovf_next;
        end
    end
endmodule

module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int S = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
    end

    // Index 0 is the incoming beat; index k+1 is the register of stage k.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:1]            vld_q;
    logic [STAGES:0]            rdy;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [STAGES:0][WIDTH-1:0] s_pipe;
    logic [STAGES:0]            c_pipe;
    logic [STAGES:1]            ovf_pipe;
    logic                       unused_bits;

    assign vld_pipe  = {vld_q, in_valid};
    assign a_pipe[0] = a;
    assign b_pipe[0] = b ^ {WIDTH{sub}};
    assign s_pipe[0] = '0;
    assign c_pipe[0] = c_in ^ sub;

    // A stage may load when it, or any stage downstream of it, has room.
    always_comb begin : ready_chain
        logic room;
        rdy         = '0;
        room        = out_ready;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room   = room | ~vld_pipe[k+1];
            rdy[k] = room;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) vld_q[k+1] <= vld_pipe[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH(WIDTH),
            .S    (S),
            .IDX  (k)
        ) u_stage (
            .clk  (iClk),
            .rst_n(iRstN),
            .load (rdy[k] & vld_pipe[k]),
            .a_in (a_pipe[k]),
            .b_in (b_pipe[k]),
            .s_in (s_pipe[k]),
            .c_in (c_pipe[k]),
            .a_q  (a_pipe[k+1]),
            .b_q  (b_pipe[k+1]),
            .s_q  (s_pipe[k+1]),
            .c_q  (c_pipe[k+1]),
            .ovf_q(ovf_pipe[k+1])
        );
    end

    assign unused_bits = ^{a_pipe[STAGES], b_pipe[STAGES], ovf_pipe};

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES];
    assign sum       = s_pipe[STAGES];
    assign c_out     = c_pipe[STAGES];
    assign ovf       = ovf_pipe[STAGES];
endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed arithmetic, reset, streaming,
// backpressure and randomized regressions on three parameter sets.
module tb_adder_pipe;
    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        c_in = 1'b0, sub = 1'b0;
    logic [2:0]  in_valid_v = '0, out_ready_v = '0;
    logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [3:0]  sum4;

    int          sel = 0;
    int          checks = 0, failures = 0;
    int          n_acc = 0, n_xfer = 0;
    logic        last_acc = 1'b0;
    logic [33:0] model[$];

    always #5 iClk = ~iClk;

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .iClk(iClk), .iRstN(iRstN), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sub(sub), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .sum(sum8), .c_out(cout_v[0]), .ovf(ovf_v[0]));

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
        .iClk(iClk), .iRstN(iRstN), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .sum(sum32), .c_out(cout_v[1]), .ovf(ovf_v[1]));

    adder_pipe #(.WIDTH(4), .STAGES(1)) dut4 (
        .iClk(iClk), .iRstN(iRstN), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a[3:0]), .b(b[3:0]), .c_in(c_in), .sub(sub), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .sum(sum4), .c_out(cout_v[2]), .ovf(ovf_v[2]));

    function automatic int width_of(int s);
        case (s)
            0:       return 8;
            1:       return 32;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(int s);
        case (s)
            0:       return {24'h0, sum8};
            1:       return sum32;
            default: return {28'h0, sum4};
        endcase
    endfunction

    // Reference: plain integer arithmetic, signed overflow by range check.
    function automatic logic [33:0] golden(logic [31:0] av, logic [31:0] bv, logic cv, logic sv, int w);
        longint m, half, x, y, c, r, sa, sb, sr;
        logic   co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        x    = longint'(av) & m;
        y    = longint'(bv) & m;
        c    = cv ? 1 : 0;
        sa   = (x >= half) ? x - (m + 1) : x;
        sb   = (y >= half) ? y - (m + 1) : y;
        if (!sv) begin
            r  = x + y + c;
            co = (r > m);
            sr = sa + sb + c;
        end else begin
            r  = x - y - c;
            co = (x >= y + c);
            sr = sa - sb - c;
        end
        ov = (sr >= half) || (sr < -half);
        return {ov, co, 32'(r & m)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_beat();
        a    = $urandom;
        b    = $urandom;
        c_in = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample handshakes after the inputs settle, score, advance to next negedge.
    task automatic cycle();
        logic        acc, xfer;
        logic [33:0] exp;
        #1;
        acc      = in_valid_v[sel] && in_ready_v[sel];
        xfer     = out_valid_v[sel] && out_ready_v[sel];
        last_acc = acc;
        if (out_valid_v[sel]) begin
            check("out_has_model", 64'(model.size() != 0), 64'd1);
            if (model.size() != 0) begin
                exp = model[0];
                check("sum", 64'(sum_of(sel)), 64'(exp[31:0]));
                check("c_out", 64'(cout_v[sel]), 64'(exp[32]));
                check("ovf", 64'(ovf_v[sel]), 64'(exp[33]));
            end
        end
        if (xfer && model.size() != 0) begin
            void'(model.pop_front());
            n_xfer++;
        end
        if (acc) begin
            model.push_back(golden(a, b, c_in, sub, width_of(sel)));
            n_acc++;
        end
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic directed(string tag, logic [7:0] av, logic [7:0] bv, logic cv, logic sv,
                            logic [7:0] es, logic ec, logic eo);
        a = {24'h0, av}; b = {24'h0, bv}; c_in = cv; sub = sv;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        #1 check($sformatf("%s_in_ready", tag), 64'(in_ready_v[0]), 64'd1);
        @(posedge iClk); @(negedge iClk);
        in_valid_v[0] = 1'b0;
        #1 check($sformatf("%s_early", tag), 64'(out_valid_v[0]), 64'd0);
        @(posedge iClk); @(negedge iClk);
        #1;
        check($sformatf("%s_valid", tag), 64'(out_valid_v[0]), 64'd1);
        check($sformatf("%s_sum", tag), 64'(sum8), 64'(es));
        check($sformatf("%s_c_out", tag), 64'(cout_v[0]), 64'(ec));
        check($sformatf("%s_ovf", tag), 64'(ovf_v[0]), 64'(eo));
        @(posedge iClk); @(negedge iClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid_v), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        check("rst_c_out", 64'(cout_v), 64'd0);
        check("rst_ovf", 64'(ovf_v), 64'd0);
        @(negedge iClk);
        iRstN = 1'b1;

        // Directed add / subtract
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        directed("sub_borrow", 8'h09, 8'h03, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
        directed("add_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);

        // Stream of 16 back-to-back beats
        sel = 0; model.delete(); n_acc = 0; n_xfer = 0;
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            new_beat();
            in_valid_v[0] = 1'b1;
            cycle();
        end
        check("stream_acc", 64'(n_acc), 64'd16);
        check("stream_xfer_mid", 64'(n_xfer), 64'd14);
        in_valid_v[0] = 1'b0;
        cycle(); cycle();
        check("stream_xfer_end", 64'(n_xfer), 64'd16);
        check("stream_empty", 64'(model.size()), 64'd0);

        // Backpressure: full input rate against a stalled consumer
        n_acc = 0; n_xfer = 0;
        out_ready_v[0] = 1'b0;
        new_beat();
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_acc) new_beat();
        end
        check("bp_absorbed", 64'(n_acc), 64'd2);
        #1 check("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
        @(negedge iClk);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 10 && model.size() != 0; i++) cycle();
        check("bp_drained", 64'(n_xfer), 64'd2);
        check("bp_empty", 64'(model.size()), 64'd0);

        // Reset mid-operation with beats in flight
        n_acc = 0; n_xfer = 0;
        out_ready_v[0] = 1'b0;
        new_beat();
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (last_acc) new_beat();
        end
        check("pre_rst_valid", 64'(out_valid_v[0]), 64'd1);
        #2 iRstN = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid_v[0]), 64'd0);
        check("midrst_sum", 64'(sum8), 64'd0);
        check("midrst_c_out", 64'(cout_v[0]), 64'd0);
        model.delete();
        @(negedge iClk);
        iRstN = 1'b1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("post_rst_quiet", 64'(out_valid_v[0]), 64'd0);
            cycle();
        end

        // Randomized regressions on the other parameter sets
        for (int s = 1; s <= 2; s++) begin
            sel = s; model.delete(); n_acc = 0; n_xfer = 0; last_acc = 1'b1;
            in_valid_v = '0;
            for (int i = 0; i < 400; i++) begin
                if (!(in_valid_v[sel] && !last_acc)) begin
                    in_valid_v[sel] = ($urandom_range(0, 3) != 0);
                    if (in_valid_v[sel]) new_beat();
                end
                out_ready_v[sel] = ($urandom_range(0, 9) < 7);
                cycle();
            end
            in_valid_v[sel]  = 1'b0;
            out_ready_v[sel] = 1'b1;
            for (int i = 0; i < 20 && model.size() != 0; i++) cycle();
            check($sformatf("regr%0d_empty", s), 64'(model.size()), 64'd0);
            check($sformatf("regr%0d_count", s), 64'(n_xfer), 64'(n_acc));
            check($sformatf("regr%0d_traffic", s), 64'(n_acc > 100), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
